// File: rtl/frame_sequencer_if.sv
// GPU / back-buffer bus seen by the frame sequencer.
// The master side is the sequencer: it takes the GPU request lines and drives
// the GPU start request plus the write port of the back buffer. The slave side
// is the GPU / frame-buffer environment.
interface frame_sequencer_if;
    logic       gpu_done;
    logic [9:0] gpu_x;
    logic [9:0] gpu_y;
    logic [3:0] gpu_data;
    logic       gpu_we;
    logic       gpu_start;
    logic [9:0] fb_x;
    logic [9:0] fb_y;
    logic [3:0] fb_data;
    logic       fb_we;

    modport master (
        input  gpu_done, gpu_x, gpu_y, gpu_data, gpu_we,
        output gpu_start, fb_x, fb_y, fb_data, fb_we
    );

    modport slave (
        output gpu_done, gpu_x, gpu_y, gpu_data, gpu_we,
        input  gpu_start, fb_x, fb_y, fb_data, fb_we
    );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer for the double-buffered frame store.
// Per frame: optionally clear the back buffer, start the GPU, wait for the GPU
// to finish, then swap buffers on the next vsync rising edge.
// Optional feature macro: FRAME_SEQ_CLEAR_EN (defined = clear sweep present,
// reset state CLEAR; undefined = no clear sweep, reset state START).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CLEAR   | sweep CLEAR_COLOR over the back buffer, row-major
// ST_START   | gpu_start high until the GPU reports busy (gpu_done==0)
// ST_RENDER  | GPU writes pass straight through; wait for gpu_done==1
// ST_WAIT_VS | writes blocked; swap buffers on the next vsync rising edge
module frame_sequencer #(
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 240,
    parameter int CLEAR_COLOR = 'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vga_vs,
    frame_sequencer_if.master   bus,
    output logic                write_buffer_sel,
    output logic [15:0]         frame_count,
    output logic [7:0]          missed_vsync
);

    // Reject parameter values that cannot fit the 10-bit coordinates or 4-bit pixels.
    if (FB_WIDTH < 1 || FB_WIDTH > 1024 || FB_HEIGHT < 1 || FB_HEIGHT > 1024 ||
        CLEAR_COLOR < 0 || CLEAR_COLOR > 15) begin : g_param_check
        $error("frame_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
`ifdef FRAME_SEQ_CLEAR_EN
        ST_CLEAR   = 2'd0,
`endif
        ST_START   = 2'd1,
        ST_RENDER  = 2'd2,
        ST_WAIT_VS = 2'd3
    } state_t;

    state_t state;

    logic vs_sync1;
    logic vs_sync2;
    logic vs_sync3;
    logic vs_rise;

`ifdef FRAME_SEQ_CLEAR_EN
    localparam logic [9:0] X_LAST = 10'(FB_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(FB_HEIGHT - 1);

    logic [9:0] clr_x;
    logic [9:0] clr_y;
`endif

    // Bring vsync into the clk domain and detect its rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_sync1 <= 1'b0;
            vs_sync2 <= 1'b0;
            vs_sync3 <= 1'b0;
        end else begin
            vs_sync1 <= vga_vs;
            vs_sync2 <= vs_sync1;
            vs_sync3 <= vs_sync2;
        end
    end

    assign vs_rise = vs_sync2 & ~vs_sync3;

    // Sequencer FSM with registered gpu_start, buffer select and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef FRAME_SEQ_CLEAR_EN
            state <= ST_CLEAR;
            clr_x <= 10'd0;
            clr_y <= 10'd0;
`else
            state <= ST_START;
`endif
            bus.gpu_start    <= 1'b0;
            write_buffer_sel <= 1'b0;
            frame_count      <= 16'd0;
            missed_vsync     <= 8'd0;
        end else begin
            // A vsync edge anywhere but WAIT_VS means this frame missed its slot.
            if (vs_rise && state != ST_WAIT_VS && missed_vsync != 8'hFF)
                missed_vsync <= missed_vsync + 8'd1;

            case (state)
`ifdef FRAME_SEQ_CLEAR_EN
                ST_CLEAR: begin
                    if (clr_x == X_LAST) begin
                        clr_x <= 10'd0;
                        if (clr_y == Y_LAST) begin
                            clr_y         <= 10'd0;
                            state         <= ST_START;
                            bus.gpu_start <= 1'b1;
                        end else begin
                            clr_y <= clr_y + 10'd1;
                        end
                    end else begin
                        clr_x <= clr_x + 10'd1;
                    end
                end
`endif
                ST_START: begin
                    if (!bus.gpu_done) begin
                        bus.gpu_start <= 1'b0;
                        state         <= ST_RENDER;
                    end else begin
                        bus.gpu_start <= 1'b1;
                    end
                end
                ST_RENDER: begin
                    if (bus.gpu_done)
                        state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    // The toggle lands with the state change, so the next
                    // frame's first write already targets the new back buffer.
                    if (vs_rise) begin
                        write_buffer_sel <= ~write_buffer_sel;
                        frame_count      <= frame_count + 16'd1;
`ifdef FRAME_SEQ_CLEAR_EN
                        state            <= ST_CLEAR;
`else
                        state            <= ST_START;
                        bus.gpu_start    <= 1'b1;
`endif
                    end
                end
                default: begin
`ifdef FRAME_SEQ_CLEAR_EN
                    state <= ST_CLEAR;
`else
                    state <= ST_START;
`endif
                end
            endcase
        end
    end

    // Back-buffer write port: clear sweep, GPU pass-through, or blocked.
    always_comb begin
        bus.fb_x    = 10'd0;
        bus.fb_y    = 10'd0;
        bus.fb_data = 4'd0;
        bus.fb_we   = 1'b0;
        case (state)
`ifdef FRAME_SEQ_CLEAR_EN
            ST_CLEAR: begin
                bus.fb_x    = clr_x;
                bus.fb_y    = clr_y;
                bus.fb_data = 4'(CLEAR_COLOR);
                bus.fb_we   = 1'b1;
            end
`endif
            ST_START, ST_RENDER: begin
                bus.fb_x    = bus.gpu_x;
                bus.fb_y    = bus.gpu_y;
                bus.fb_data = bus.gpu_data;
                bus.fb_we   = bus.gpu_we;
            end
            default: begin
                bus.fb_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x2 frame store.
// Covers both builds: with FRAME_SEQ_CLEAR_EN the clear sweep is checked,
// without it the sequencer starts straight in START.
module tb_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        vga_vs;
    logic        write_buffer_sel;
    logic [15:0] frame_count;
    logic [7:0]  missed_vsync;

    int n_chk;
    int n_err;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .FB_WIDTH    (4),
        .FB_HEIGHT   (2),
        .CLEAR_COLOR ('h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .vga_vs           (vga_vs),
        .bus              (bus),
        .write_buffer_sel (write_buffer_sel),
        .frame_count      (frame_count),
        .missed_vsync     (missed_vsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full vsync pulse, long enough for the synchronizer to see both edges.
    task automatic vs_pulse();
        vga_vs = 1'b1;
        tick();
        tick();
        vga_vs = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset        = 1'b0;
        vga_vs       = 1'b0;
        bus.gpu_done = 1'b1;
        bus.gpu_x    = 10'd0;
        bus.gpu_y    = 10'd0;
        bus.gpu_data = 4'd0;
        bus.gpu_we   = 1'b0;
        tick();
        tick();
        tick();

        chk("rst_gpu_start", 32'(bus.gpu_start), 32'd0);
        chk("rst_sel", 32'(write_buffer_sel), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_missed", 32'(missed_vsync), 32'd0);

        reset = 1'b1;
`ifdef FRAME_SEQ_CLEAR_EN
        // Eight clear writes (0,0)..(3,1), colour 0, before the GPU is started.
        for (int i = 0; i < 8; i++) begin
            chk("clr_we", 32'(bus.fb_we), 32'd1);
            chk("clr_x", 32'(bus.fb_x), 32'(i % 4));
            chk("clr_y", 32'(bus.fb_y), 32'(i / 4));
            chk("clr_data", 32'(bus.fb_data), 32'd0);
            chk("clr_no_start", 32'(bus.gpu_start), 32'd0);
            tick();
        end
`else
        chk("nc_no_we_at_release", 32'(bus.fb_we), 32'd0);
        tick();
`endif
        chk("start_first_cycle", 32'(bus.gpu_start), 32'd1);
        chk("start_no_we", 32'(bus.fb_we), 32'd0);

        // gpu_done still high: start request is held.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("start_hold", 32'(bus.gpu_start), 32'd1);
        end
        bus.gpu_done = 1'b0;
        tick();
        chk("start_drop", 32'(bus.gpu_start), 32'd0);

        // RENDER: same-cycle pass-through of a GPU write.
        bus.gpu_we   = 1'b1;
        bus.gpu_x    = 10'd2;
        bus.gpu_y    = 10'd1;
        bus.gpu_data = 4'hA;
        #1;
        chk("pass_we", 32'(bus.fb_we), 32'd1);
        chk("pass_x", 32'(bus.fb_x), 32'd2);
        chk("pass_y", 32'(bus.fb_y), 32'd1);
        chk("pass_data", 32'(bus.fb_data), 32'hA);
        bus.gpu_x    = 10'd3;
        bus.gpu_data = 4'h5;
        #1;
        chk("pass_x2", 32'(bus.fb_x), 32'd3);
        chk("pass_data2", 32'(bus.fb_data), 32'h5);
        bus.gpu_we = 1'b0;

        // 300 vsync edges while rendering: counted, saturating, no swap.
        for (int i = 0; i < 3; i++) vs_pulse();
        chk("missed_3", 32'(missed_vsync), 32'd3);
        for (int i = 3; i < 255; i++) vs_pulse();
        chk("missed_255", 32'(missed_vsync), 32'd255);
        for (int i = 255; i < 300; i++) vs_pulse();
        tick();
        tick();
        tick();
        chk("missed_sat", 32'(missed_vsync), 32'd255);
        chk("missed_no_swap", 32'(write_buffer_sel), 32'd0);
        chk("missed_no_count", 32'(frame_count), 32'd0);

        // GPU finishes: WAIT_VS blocks writes and zeroes the port.
        bus.gpu_done = 1'b1;
        tick();
        bus.gpu_we   = 1'b1;
        bus.gpu_x    = 10'd3;
        bus.gpu_y    = 10'd1;
        bus.gpu_data = 4'hF;
        #1;
        chk("wait_we_blocked", 32'(bus.fb_we), 32'd0);
        chk("wait_x_zero", 32'(bus.fb_x), 32'd0);
        chk("wait_data_zero", 32'(bus.fb_data), 32'd0);
        bus.gpu_we   = 1'b0;
        bus.gpu_x    = 10'd0;
        bus.gpu_y    = 10'd0;
        bus.gpu_data = 4'd0;

        // Vsync rise: swap appears on the third clock edge after it.
        vga_vs = 1'b1;
        tick();
        tick();
        chk("swap_not_yet", 32'(write_buffer_sel), 32'd0);
        tick();
        chk("swap_sel", 32'(write_buffer_sel), 32'd1);
        chk("swap_count", 32'(frame_count), 32'd1);
        chk("swap_missed_kept", 32'(missed_vsync), 32'd255);
        vga_vs = 1'b0;
`ifdef FRAME_SEQ_CLEAR_EN
        chk("reclr_we", 32'(bus.fb_we), 32'd1);
        chk("reclr_x", 32'(bus.fb_x), 32'd0);
        chk("reclr_y", 32'(bus.fb_y), 32'd0);
        tick();
        tick();
        chk("midclr_x", 32'(bus.fb_x), 32'd2);
        chk("midclr_y", 32'(bus.fb_y), 32'd0);
`else
        chk("restart_gpu_start", 32'(bus.gpu_start), 32'd1);
        chk("restart_no_we", 32'(bus.fb_we), 32'd0);
        tick();
`endif

        // Reset in the middle of a frame aborts everything.
        reset = 1'b0;
        tick();
        chk("rst2_gpu_start", 32'(bus.gpu_start), 32'd0);
        chk("rst2_sel", 32'(write_buffer_sel), 32'd0);
        chk("rst2_frame_count", 32'(frame_count), 32'd0);
        chk("rst2_missed", 32'(missed_vsync), 32'd0);
        reset = 1'b1;
`ifdef FRAME_SEQ_CLEAR_EN
        chk("rst2_clr_x0", 32'(bus.fb_x), 32'd0);
        chk("rst2_clr_y0", 32'(bus.fb_y), 32'd0);
        chk("rst2_clr_we", 32'(bus.fb_we), 32'd1);
        tick();
        chk("rst2_clr_x1", 32'(bus.fb_x), 32'd1);
        chk("rst2_clr_y1", 32'(bus.fb_y), 32'd0);
`else
        tick();
        chk("rst2_start_again", 32'(bus.gpu_start), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
